// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU control
// and multiply/divide sequencer.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOR = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_LUI = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;
  localparam logic [3:0] ALU_NOP = 4'b1001;

  localparam logic [2:0] OP_LUI  = 3'b000;
  localparam logic [2:0] OP_BR   = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_MEM  = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_ORI  = 3'b101;
  localparam logic [2:0] OP_ANDI = 3'b110;
  localparam logic [2:0] OP_R    = 3'b111;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_JR    = 6'b001000;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational ALUOp/funct decode: ALU code,
// JR flag and mul/div / HI-LO move classification.
module alu_decode
  import alu_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_operation,
  output logic       jump_register,
  output logic       is_muldiv,
  output logic [1:0] muldiv_op,
  output logic       is_mfhi,
  output logic       is_mflo
);

  logic is_r;

  assign is_r = (alu_op == OP_R);

  // ALU operation code and JR flag
  always_comb begin
    alu_operation = ALU_NOP;
    jump_register = 1'b0;
    unique case (1'b1)
      is_r: begin
        case (funct)
          F_AND: alu_operation = ALU_AND;
          F_OR:  alu_operation = ALU_OR;
          F_NOR: alu_operation = ALU_NOR;
          F_ADD: alu_operation = ALU_ADD;
          F_SUB: alu_operation = ALU_SUB;
          F_SLL: alu_operation = ALU_SLL;
          F_SRL: alu_operation = ALU_SRL;
          F_SLT: alu_operation = ALU_SLT;
          F_JR: begin
            alu_operation = ALU_NOP;
            jump_register = 1'b1;
          end
          default: alu_operation = ALU_NOP;
        endcase
      end
      (alu_op == OP_ADDI): alu_operation = ALU_ADD;
      (alu_op == OP_ORI):  alu_operation = ALU_OR;
      (alu_op == OP_ANDI): alu_operation = ALU_AND;
      (alu_op == OP_LUI):  alu_operation = ALU_LUI;
      (alu_op == OP_MEM):  alu_operation = ALU_ADD;
      (alu_op == OP_BR):   alu_operation = ALU_SUB;
      default:             alu_operation = ALU_NOP;
    endcase
  end

  // mul/div class and HI/LO moves exist only as R-type
  always_comb begin
    is_muldiv = 1'b0;
    muldiv_op = MD_MULT;
    if (is_r) begin
      case (funct)
        F_MULT: begin
          is_muldiv = 1'b1;
          muldiv_op = MD_MULT;
        end
        F_MULTU: begin
          is_muldiv = 1'b1;
          muldiv_op = MD_MULTU;
        end
        F_DIV: begin
          is_muldiv = 1'b1;
          muldiv_op = MD_DIV;
        end
        F_DIVU: begin
          is_muldiv = 1'b1;
          muldiv_op = MD_DIVU;
        end
        default: begin
          is_muldiv = 1'b0;
          muldiv_op = MD_MULT;
        end
      endcase
    end
  end

  assign is_mfhi = is_r & (funct == F_MFHI);
  assign is_mflo = is_r & (funct == F_MFLO);

endmodule

// File: rtl/alu_control_muldiv.sv
// ALU control with iterative mul/div sequencer,
// HI/LO write strobe and decode-stage interlock.
module alu_control_muldiv
  import alu_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 32,
  parameter int CNT_WIDTH   = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] ALUOp,
  input  logic [5:0] ALUFunction,
  input  logic       i_Valid,
  output logic [3:0] ALUOperation,
  output logic       o_JumpRegister,
  output logic       o_MulDivStart,
  output logic [1:0] o_MulDivOp,
  output logic       o_HiLoWrite,
  output logic       o_HiLoSelect,
  output logic       o_Stall,
  output logic       o_Busy
);

  localparam logic [CNT_WIDTH-1:0] MUL_LOAD =
    CNT_WIDTH'(MUL_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] DIV_LOAD =
    CNT_WIDTH'(DIV_LATENCY - 1);

  logic                 is_muldiv;
  logic                 is_mfhi;
  logic                 is_mflo;
  logic [1:0]           md_op;
  logic                 idle;
  logic                 uses_hilo;
  logic                 start;
  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 busy_q;
  logic                 hilo_q;

  alu_decode u_decode (
    .alu_op        (ALUOp),
    .funct         (ALUFunction),
    .alu_operation (ALUOperation),
    .jump_register (o_JumpRegister),
    .is_muldiv     (is_muldiv),
    .muldiv_op     (md_op),
    .is_mfhi       (is_mfhi),
    .is_mflo       (is_mflo)
  );

  assign idle      = (state == ST_IDLE);
  assign uses_hilo = is_muldiv | is_mfhi | is_mflo;

  // reset gating keeps start/stall quiet while held
  assign start   = reset & i_Valid & is_muldiv & idle;
  assign o_Stall = reset & i_Valid & uses_hilo & ~idle;

  assign o_MulDivStart = start;
  assign o_MulDivOp    = md_op;
  assign o_HiLoSelect  = is_mfhi;
  assign o_HiLoWrite   = hilo_q;
  assign o_Busy        = busy_q;

  // sequencer: IDLE -> BUSY (latency cycles) -> DONE
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      hilo_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_BUSY;
            cnt    <= md_op[1] ? DIV_LOAD : MUL_LOAD;
            busy_q <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            state  <= ST_DONE;
            hilo_q <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          hilo_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
          hilo_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_control_muldiv.md
Name: alu_control_muldiv

Overview:
- Next-generation ALU control unit for the MIPS datapath.
- Keeps the combinational ALUOp/funct decode to a 4-bit ALU operation code and the jump-register flag.
- Adds a sequencer for the iterative multiply/divide unit (MULT, MULTU, DIV, DIVU), with HI/LO write strobes and a pipeline interlock for MFHI/MFLO and back-to-back mul/div.
- Sits in the decode/execute stage, between the main control unit and the ALU / muldiv unit.

Parameters:
- MUL_LATENCY, 4, number of BUSY cycles for MULT/MULTU (must be >= 1)
- DIV_LATENCY, 32, number of BUSY cycles for DIV/DIVU (must be >= 1)
- CNT_WIDTH, 6, latency counter width; must satisfy 2^CNT_WIDTH > max(MUL_LATENCY, DIV_LATENCY) - 1

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- ALUOp  input  3  operation class from the control unit
- ALUFunction  input  6  instruction funct field
- i_Valid  input  1  decoded instruction is live; not a bubble or flush
- ALUOperation  output  4  ALU operation code
- o_JumpRegister  output  1  instruction is JR
- o_MulDivStart  output  1  one-cycle start pulse to the muldiv unit
- o_MulDivOp  output  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; valid with o_MulDivStart
- o_HiLoWrite  output  1  one-cycle strobe: write the muldiv result into HI/LO
- o_HiLoSelect  output  1  0 selects LO, 1 selects HI; valid for MFLO/MFHI
- o_Stall  output  1  hold the decode stage this cycle
- o_Busy  output  1  sequencer state is not IDLE

Behaviour:
- Decode is combinational on {ALUOp, ALUFunction}:
  - R-type (ALUOp 111): AND 100100 -> 0000; OR 100101 -> 0001; NOR 100111 -> 0010; ADD 100000 -> 0011; SUB 100010 -> 0100; SLL 000000 -> 0101; SRL 000010 -> 0110; SLT 101010 -> 1000; JR 001000 -> 1001 with o_JumpRegister = 1.
  - I-type: ADDI (100) -> 0011; ORI (101) -> 0001; ANDI (110) -> 0000; LUI (000) -> 0111; LW/SW (011) -> 0011; branch (001) -> 0100.
  - J (010) -> 1001.
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MFLO 010010 -> 1001 (ALU idle).
  - Any other combination -> 1001.
- o_HiLoSelect = 1 for MFHI, 0 otherwise.
- FSM states: IDLE, BUSY, DONE. Registered state and counter; reset gives state = IDLE, counter = 0.
- Reset values of registered outputs: o_MulDivStart 0, o_HiLoWrite 0, o_Busy 0, o_Stall 0.
- Sequencer timing:
  - IDLE: a mul/div funct with i_Valid = 1 in cycle T asserts o_MulDivStart and o_MulDivOp combinationally in T, with no stall. The counter loads LATENCY-1 (MUL or DIV per the funct) and the FSM goes to BUSY.
  - BUSY: counter decrements each cycle. When counter == 0, go to DONE. BUSY lasts exactly LATENCY cycles (T+1 .. T+LATENCY).
  - DONE: cycle T+LATENCY+1; o_HiLoWrite = 1 for exactly this cycle; next state IDLE unconditionally.
  - A mul/div in IDLE at T+LATENCY+2 is accepted.
- Interlock:
  - o_Stall = i_Valid & (is_muldiv | is_mfhi | is_mflo) & (state != IDLE).
  - MFHI/MFLO in DONE still stalls, because HI/LO is written at the end of DONE.
  - A stalled mul/div does not start. The pipeline re-presents it and it is accepted in the first IDLE cycle.
- i_Valid = 0: no start and no stall; decode outputs are still driven.
- Mul/div encodings with ALUOp != 111 are not mul/div.
- Reset asserted mid-operation (any state): next cycle is IDLE, counter 0, no o_HiLoWrite. The muldiv result is discarded.
- Latency 1: counter loads 0; BUSY lasts 1 cycle, then DONE.

Decomposition:
- Shared package alu_pkg holds:
  - ALU operation code constants (AND..SLT, NOP = 1001);
  - ALUOp class constants;
  - funct constants, including the mul/div and MFHI/MFLO codes;
  - the muldiv op encoding;
  - the FSM state typedef.
- One sub-module, alu_decode, holds the pure combinational decode. It outputs ALUOperation, o_JumpRegister, is_muldiv, the muldiv op, is_mfhi and is_mflo.
- The top level holds the FSM, counter and interlock.

Test Plan:
- Decode sweep: each R/I/J encoding above gives the listed code; ALUOp = 111 with funct 111111 gives 1001; JR (111_001000) sets o_JumpRegister = 1.
- MULT (111_011000) with i_Valid in IDLE at cycle 0, MUL_LATENCY = 4:
  - cycle 0: o_MulDivStart = 1, op = 00;
  - cycles 1–4: o_Busy = 1;
  - cycle 5: o_HiLoWrite = 1;
  - cycle 6: IDLE.
- MFHI presented every cycle from cycle 1 after DIVU (DIV_LATENCY = 32): o_Stall = 1 on cycles 1–33, o_Stall = 0 on cycle 34, o_HiLoSelect = 1 throughout.
- Back-to-back DIV then MULT: the MULT stalls through DONE; o_MulDivStart for the MULT fires in the first IDLE cycle with op = 00.
- reset = 0 on cycle 3 of a DIV: the next cycle shows o_Busy = 0; o_HiLoWrite never asserts; a new MULT is accepted immediately.
- i_Valid = 0 with a MULT funct in IDLE, and MFLO with i_Valid = 0 during BUSY: no o_MulDivStart, o_Stall = 0.
